adder_rca_pipelined: RTL

Parametrised, pipelined ripple-carry adder/subtractor and the generalised successor of the fixed 33-bit combinational RCA in the multiplier datapath. The operand is split into `STAGES` ripple chunks, with one registered chunk per pipeline stage, so the critical path is one chunk instead of the full width. A valid/ready handshake with per-stage bubble collapsing is provided at both ends. The block also adds a subtract mode and a signed-overflow flag. It is used for partial-product accumulation and final-sum stages where full-width combinational ripple misses timing.

---
 rtl/adder_rca_pipelined_if.sv | 27 ++
 rtl/adder_rca_pipelined.sv | 116 +++++++++++
 2 files changed

// File: rtl/adder_rca_pipelined_if.sv
// Operand/result bundle for the pipelined ripple-carry adder/subtractor.
// The master side drives operands and the result ready; the slave side is the adder.
interface adder_rca_pipelined_if #(
  parameter int unsigned WIDTH = 33
) ();
  logic             valid_i;
  logic             ready_o;
  logic             sub_i;
  logic             C_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] S_o;
  logic             C_o;
  logic             V_o;

  modport master (
    output valid_i, sub_i, C_i, A_i, B_i, ready_i,
    input  ready_o, valid_o, S_o, C_o, V_o
  );

  modport slave (
    input  valid_i, sub_i, C_i, A_i, B_i, ready_i,
    output ready_o, valid_o, S_o, C_o, V_o
  );
endinterface

// File: rtl/adder_rca_pipelined.sv
// Pipelined ripple-carry adder/subtractor: one CW-bit ripple chunk per stage,
// valid/ready handshake with per-stage bubble collapsing.
module adder_rca_pipelined #(
  parameter int unsigned WIDTH  = 33,
  parameter int unsigned STAGES = 3
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  adder_rca_pipelined_if.slave bus_io
);

  localparam int CW = (int'(WIDTH) + int'(STAGES) - 1) / int'(STAGES);

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    // Bit range [Lo, Hi) rippled in this stage; may be empty for late stages
    localparam int Lo = k * CW;
    localparam int Hi = ((k + 1) * CW < int'(WIDTH)) ? (k + 1) * CW : int'(WIDTH);

    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in, cm_in, v_in;
    logic             rdy, rdy_nxt, load, carry;
    logic [WIDTH-1:0] s_d, s_q;
    logic             c_d, c_q, cm_d, cm_q, v_d, v_q;

    if (k == 0) begin : g_src
      // B is inverted once at entry; later stages only ever add
      assign a_in  = bus_io.A_i;
      assign b_in  = bus_io.sub_i ? ~bus_io.B_i : bus_io.B_i;
      assign c_in  = bus_io.sub_i | bus_io.C_i;
      assign cm_in = 1'b0;
      assign s_in  = '0;
      assign v_in  = bus_io.valid_i;
    end else begin : g_chain
      assign a_in  = g_stage[k-1].g_ops.a_q;
      assign b_in  = g_stage[k-1].g_ops.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign cm_in = g_stage[k-1].cm_q;
      assign s_in  = g_stage[k-1].s_q;
      assign v_in  = g_stage[k-1].v_q;
    end

    if (k == int'(STAGES) - 1) begin : g_tail
      assign rdy_nxt = bus_io.ready_i;
    end else begin : g_body
      assign rdy_nxt = g_stage[k+1].rdy;
    end

    // An empty stage always accepts, which collapses bubbles under back-pressure
    assign rdy  = !v_q | rdy_nxt;
    assign load = rdy & v_in;

    // Ripple this stage's chunk on top of the upstream partial sum
    always_comb begin
      s_d   = s_q;
      c_d   = c_q;
      cm_d  = cm_q;
      carry = c_in;
      v_d   = rdy ? v_in : v_q;
      if (load) begin
        s_d  = s_in;
        cm_d = cm_in;
        for (int i = 0; i < int'(WIDTH); i++) begin
          if (i >= Lo && i < Hi) begin
            if (i == int'(WIDTH) - 1) cm_d = carry;
            s_d[i] = a_in[i] ^ b_in[i] ^ carry;
            carry  = (a_in[i] & b_in[i]) | (carry & (a_in[i] ^ b_in[i]));
          end
        end
        c_d = carry;
      end
    end

    // Stage state register; data only moves when a valid operation enters
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s_q  <= '0;
        c_q  <= 1'b0;
        cm_q <= 1'b0;
        v_q  <= 1'b0;
      end else begin
        s_q  <= s_d;
        c_q  <= c_d;
        cm_q <= cm_d;
        v_q  <= v_d;
      end
    end

    if (k < int'(STAGES) - 1) begin : g_ops
      logic [WIDTH-1:0] a_d, a_q, b_d, b_q;

      // Forward operands for the chunks still to be rippled
      always_comb begin
        a_d = load ? a_in : a_q;
        b_d = load ? b_in : b_q;
      end

      // Operand pipeline register
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign bus_io.ready_o = g_stage[0].rdy;
  assign bus_io.valid_o = g_stage[STAGES-1].v_q;
  assign bus_io.S_o     = g_stage[STAGES-1].s_q;
  assign bus_io.C_o     = g_stage[STAGES-1].c_q;
  assign bus_io.V_o     = g_stage[STAGES-1].c_q ^ g_stage[STAGES-1].cm_q;

endmodule
